// File: rtl/jtkcpu_ea_indir.sv
// Effective-address resolver: forwards the index address directly, or fetches a
// big-endian 16-bit pointer from memory at that address and returns it as the EA.
module jtkcpu_ea_indir #(
    parameter int DUMMY = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        i_cen,
    input  logic        i_start,
    input  logic [15:0] i_idx_addr,
    input  logic        i_indirect,
    input  logic        i_bus_ok,
    input  logic [7:0]  i_bus_din,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_rd,
    output logic [15:0] o_ea,
    output logic        o_ea_vld,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUMMY,
        ST_RDHI,
        ST_RDLO,
        ST_DONE
    } state_t;

    localparam logic [1:0] LP_CNT_LAST = 2'(DUMMY - 1);

    state_t      r_state;
    state_t      w_nxt;
    logic [15:0] r_ptr;
    logic [15:0] r_bus_addr;
    logic [15:0] r_ea;
    logic [1:0]  r_cnt;
    logic [15:0] w_ptr_inc;

    assign w_ptr_inc = r_ptr + 16'd1;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (!i_indirect)     w_nxt = ST_DONE;
                    else if (DUMMY == 0) w_nxt = ST_RDHI;
                    else                 w_nxt = ST_DUMMY;
                end
            end
            ST_DUMMY: if (r_cnt == LP_CNT_LAST) w_nxt = ST_RDHI;
            ST_RDHI:  if (i_bus_ok) w_nxt = ST_RDLO;
            ST_RDLO:  if (i_bus_ok) w_nxt = ST_DONE;
            ST_DONE:  w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
        endcase
    end

    // The bus address is loaded on entry to each read state so it is already
    // stable when the read strobe (decoded from state) goes high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 16'h0000;
            r_bus_addr <= 16'h0000;
            r_ea       <= 16'h0000;
            r_cnt      <= 2'd0;
        end else if (i_cen) begin
            r_state <= w_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (!i_indirect) begin
                            r_ea <= i_idx_addr;
                        end else begin
                            r_ptr <= i_idx_addr;
                            r_cnt <= 2'd0;
                            if (DUMMY == 0) r_bus_addr <= i_idx_addr;
                        end
                    end
                end
                ST_DUMMY: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == LP_CNT_LAST) r_bus_addr <= r_ptr;
                end
                ST_RDHI: begin
                    if (i_bus_ok) begin
                        r_ea[15:8] <= i_bus_din;
                        r_bus_addr <= w_ptr_inc;
                    end
                end
                ST_RDLO: begin
                    if (i_bus_ok) r_ea[7:0] <= i_bus_din;
                end
                default: ;
            endcase
        end
    end

    assign o_bus_addr = r_bus_addr;
    assign o_bus_rd   = (r_state == ST_RDHI) || (r_state == ST_RDLO);
    assign o_ea       = r_ea;
    assign o_ea_vld   = (r_state == ST_DONE);
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_jtkcpu_ea_indir.sv
// Bench for jtkcpu_ea_indir: randomized requests against a cycle-indexed
// reference model of the resolver's latency, bus reads and resulting EA.
module tb_jtkcpu_ea_indir;

    localparam int DUMMY = 1;

    logic        rst, clk, cen, start, ind, bus_ok, bus_rd, ea_vld, busy;
    logic [15:0] idx, bus_addr, ea;
    logic [7:0]  bus_din;
    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q[$];
    int          vld_cnt = 0;
    int          errors  = 0;
    int          checks  = 0;

    jtkcpu_ea_indir #(.DUMMY(DUMMY)) dut (
        .rst        (rst),
        .clk        (clk),
        .i_cen      (cen),
        .i_start    (start),
        .i_idx_addr (idx),
        .i_indirect (ind),
        .i_bus_ok   (bus_ok),
        .i_bus_din  (bus_din),
        .o_bus_addr (bus_addr),
        .o_bus_rd   (bus_rd),
        .o_ea       (ea),
        .o_ea_vld   (ea_vld),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus_din = mem[bus_addr];

    always @(posedge clk) begin
        if (!rst && cen && bus_rd && bus_ok) rd_q.push_back(bus_addr);
        if (!rst && cen && ea_vld) vld_cnt++;
    end

    // One request; the model indexes every cen cycle k after the start cycle (k=0)
    // and derives read window, addresses and ea_vld time from the bus_ok schedule.
    task automatic run_req(input logic [15:0] a, input logic ind_i, input int stalls,
                           input bit rnd_ok, input bit half, input bit extra);
        bit          ok [64];
        int          r0, klast, lat, kc, reads, clks, cnt, vld0;
        bit          done, exp_rd;
        logic [15:0] a1, exp_ea, exp_addr;
        r0 = DUMMY + 1;
        a1 = a + 16'd1;
        exp_ea = ind_i ? {mem[a], mem[a1]} : a;
        for (int k = 0; k < 64; k++) ok[k] = rnd_ok ? ($urandom % 4 != 0) : 1'($urandom % 2);
        if (!rnd_ok) begin
            for (int k = 0; k < stalls; k++) ok[r0 + k] = 1'b0;
            ok[r0 + stalls]     = 1'b1;
            ok[r0 + stalls + 1] = 1'b1;
        end
        ok[58] = 1'b1; ok[59] = 1'b1;
        klast = 0; cnt = 0;
        if (ind_i) begin
            for (int k = r0; k < 60; k++) begin
                if (ok[k]) cnt++;
                if (cnt == 2) begin klast = k; break; end
            end
        end
        lat = ind_i ? klast + 1 : 1;

        rd_q.delete();
        vld0 = vld_cnt;
        @(negedge clk);
        start = 1'b1; idx = a; ind = ind_i; cen = 1'b1; bus_ok = ok[0];
        kc = 0; reads = 0; clks = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            clks++;
            if (cen) begin
                if (ind_i && kc >= r0 && kc <= klast && ok[kc]) reads++;
                kc++;
            end
            exp_rd   = ind_i && kc >= r0 && kc <= klast;
            exp_addr = (reads == 0) ? a : a1;
            checks++;
            if (ea_vld !== (kc == lat)) begin
                errors++; $display("FAIL ea_vld k=%0d got %b want %b", kc, ea_vld, kc == lat);
            end
            checks++;
            if (busy !== (kc <= lat)) begin
                errors++; $display("FAIL busy k=%0d got %b want %b", kc, busy, kc <= lat);
            end
            checks++;
            if (bus_rd !== exp_rd) begin
                errors++; $display("FAIL bus_rd k=%0d got %b want %b", kc, bus_rd, exp_rd);
            end
            if (exp_rd) begin
                checks++;
                if (bus_addr !== exp_addr) begin
                    errors++; $display("FAIL bus_addr k=%0d got %h want %h", kc, bus_addr, exp_addr);
                end
            end
            if (kc >= lat) begin
                checks++;
                if (ea !== exp_ea) begin
                    errors++; $display("FAIL ea k=%0d got %h want %h", kc, ea, exp_ea);
                end
            end
            if (kc > lat) done = 1'b1;
            if (clks > 300) begin
                errors++; checks++; done = 1'b1;
                $display("FAIL timeout got k=%0d want ea_vld at k=%0d", kc, lat);
            end
            cen    = half ? !cen : 1'b1;
            bus_ok = cen ? ok[kc < 64 ? kc : 63] : 1'($urandom % 2);
            if (extra && !done && kc <= lat) begin
                start = 1'($urandom % 2); idx = 16'($urandom); ind = 1'($urandom % 2);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0; cen = 1'b1;
        checks++;
        if (vld_cnt - vld0 !== 1) begin
            errors++; $display("FAIL vld_pulses got %0d want 1", vld_cnt - vld0);
        end
        checks++;
        if (rd_q.size() !== (ind_i ? 2 : 0)) begin
            errors++; $display("FAIL read_count got %0d want %0d", rd_q.size(), ind_i ? 2 : 0);
        end else if (ind_i) begin
            checks++;
            if (rd_q[0] !== a || rd_q[1] !== a1) begin
                errors++; $display("FAIL read_addrs got %h,%h want %h,%h", rd_q[0], rd_q[1], a, a1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b0; start = 1'b0; idx = 16'h0; ind = 1'b0; bus_ok = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_addr, bus_rd, ea, ea_vld, busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset got addr=%h rd=%b ea=%h vld=%b busy=%b want all 0",
                     bus_addr, bus_rd, ea, ea_vld, busy);
        end
        rst = 1'b0; cen = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_direct();
        run_req(16'h1234, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_indirect();
        mem[16'h2000] = 8'hAB; mem[16'h2001] = 8'hCD;
        run_req(16'h2000, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ea !== 16'hABCD) begin
            errors++; $display("FAIL indirect_ea got %h want abcd", ea);
        end
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
        run_req(16'hFFFF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ea !== 16'h1234) begin
            errors++; $display("FAIL wrap_ea got %h want 1234", ea);
        end
    endtask

    task automatic test_stall();
        run_req(16'h3456, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_half_cen_busy_starts();
        run_req(16'h4000, 1'b1, 1, 1'b0, 1'b1, 1'b1);
        run_req(16'h5A5A, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_read();
        int vld0;
        rd_q.delete();
        vld0 = vld_cnt;
        @(negedge clk);
        start = 1'b1; idx = 16'h6000; ind = 1'b1; cen = 1'b1; bus_ok = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (DUMMY + 1) @(negedge clk);
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 16'h6001) begin
            errors++; $display("FAIL pre_reset_rdlo got rd=%b addr=%h want 1,6001", bus_rd, bus_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_rd !== 1'b0 || busy !== 1'b0 || ea !== 16'h0 || ea_vld !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rd=%b busy=%b ea=%h vld=%b want 0,0,0000,0",
                     bus_rd, busy, ea, ea_vld);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (vld_cnt !== vld0 || busy !== 1'b0) begin
            errors++; $display("FAIL aborted_req got vld=%0d busy=%b want 0,0", vld_cnt - vld0, busy);
        end
        mem[16'h7000] = 8'h9E; mem[16'h7001] = 8'h5F;
        run_req(16'h7000, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_req(16'($urandom), 1'($urandom % 2), 0, 1'b1, 1'($urandom % 2), 1'($urandom % 2));
            repeat ($urandom % 3) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_direct();
        test_indirect();
        test_wrap();
        test_stall();
        test_half_cen_busy_starts();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
